cache_controller: RTL and testbench

Miss-handling controller for the 64-line direct-mapped, write-back, write-allocate data cache. It sits between the CPU load/store port and the Cache storage array. It drives the array's address, write-enable and valid/dirty flags. On a miss it runs the main-memory side: dirty victim writeback, then line refill through a req/ready handshake. Word-addressed: index = addr[5:0], tag = addr[15:6].

---
 rtl/cache_controller.sv | 116 +++++++++++
 tb/tb_cache_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: miss-handling FSM for a 64-line direct-mapped write-back, write-allocate cache
module cache_controller #(
    parameter int ADDR_W = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [31:0]       cache_wdata,
    output logic              we_cache,
    output logic              set_valid,
    output logic              set_dirty,
    input  logic              cache_hit,
    input  logic              cache_valid,
    input  logic              cache_dirty,
    input  logic [ADDR_W-7:0] victim_tag,
    input  logic [31:0]       cache_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0] req_wdata;
    logic req_wr, missed;
    logic accept, miss, done;
    assign accept = (state == IDLE) && (cpu_rd || cpu_wr) && !cpu_ready;
    assign miss = (state == COMPARE) && !cache_hit;
    assign done = (state == COMPARE) && cache_hit;
    always_comb begin
        state_n = state;
        cache_addr = req_addr;
        cache_wdata = '0;
        we_cache = 1'b0;
        set_valid = 1'b0;
        set_dirty = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        case (state)
            IDLE: state_n = accept ? COMPARE : IDLE;
            COMPARE: begin
                if (cache_hit) begin
                    state_n = IDLE;
                    we_cache = req_wr && !reset;
                    cache_wdata = req_wr ? req_wdata : '0;
                    set_valid = req_wr;
                    set_dirty = req_wr;
                end else begin
                    state_n = (cache_valid && cache_dirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req = 1'b1;
                mem_we = 1'b1;
                mem_addr = {victim_tag, req_addr[5:0]};
                mem_wdata = cache_rdata;
                state_n = mem_ready ? REFILL : WRITEBACK;
            end
            REFILL: begin
                mem_req = 1'b1;
                mem_addr = req_addr;
                if (mem_ready) begin
                    // a reset in this cycle abandons the refill without touching the array
                    we_cache = !reset;
                    cache_wdata = mem_rdata;
                    set_valid = 1'b1;
                    state_n = COMPARE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req_addr <= '0;
            req_wdata <= '0;
            req_wr <= 1'b0;
            missed <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            hit_count <= '0;
            miss_count <= '0;
            wb_count <= '0;
        end else begin
            state <= state_n;
            cpu_ready <= done;
            cpu_rdata <= (done && !req_wr) ? cache_rdata : '0;
            if (accept) begin
                req_addr <= cpu_addr;
                req_wdata <= cpu_wdata;
                req_wr <= cpu_wr;
            end
            if (miss) missed <= 1'b1;
            else if (done) missed <= 1'b0;
            if (miss && !missed) miss_count <= miss_count + CNT_W'(1);
            if (miss && cache_valid && cache_dirty) wb_count <= wb_count + CNT_W'(1);
            if (done && !missed) hit_count <= hit_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed bench with cache array and memory models plus scoreboards
module tb_cache_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata, cache_wdata, cache_rdata, mem_wdata, mem_rdata;
    logic cpu_ready, we_cache, set_valid, set_dirty, cache_hit, cache_valid, cache_dirty;
    logic [15:0] cache_addr, mem_addr, hit_count, miss_count, wb_count;
    logic [9:0] victim_tag;
    logic mem_req, mem_we, mem_ready;
    int n_cmp = 0;
    int n_fail = 0;
    int mem_wait = 0;
    int wcnt = 0;
    bit vld [64];
    bit dty [64];
    bit [9:0] tg [64];
    bit [31:0] dat [64];
    bit [31:0] mem [65536];
    bit wrt [65536];
    typedef struct {logic cd; logic [31:0] data; int lat;} cpu_exp_t;
    typedef struct {logic we; logic [15:0] addr; logic [31:0] data;} mem_exp_t;
    cpu_exp_t cpu_q [$];
    mem_exp_t mem_q [$];

    cache_controller dut (
        .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .we_cache(we_cache),
        .set_valid(set_valid), .set_dirty(set_dirty), .cache_hit(cache_hit),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty), .victim_tag(victim_tag),
        .cache_rdata(cache_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] preload(input logic [15:0] a);
        return (a == 16'h0045) ? 32'hDEADBEEF : {16'hA5A5, a};
    endfunction

    // storage array: tag/valid/dirty/data per index, written only on we_cache
    assign cache_hit = vld[cache_addr[5:0]] && (tg[cache_addr[5:0]] == cache_addr[15:6]);
    assign cache_valid = vld[cache_addr[5:0]];
    assign cache_dirty = dty[cache_addr[5:0]];
    assign victim_tag = tg[cache_addr[5:0]];
    assign cache_rdata = dat[cache_addr[5:0]];
    always @(posedge clk) begin
        if (we_cache) begin
            dat[cache_addr[5:0]] <= cache_wdata;
            vld[cache_addr[5:0]] <= set_valid;
            dty[cache_addr[5:0]] <= set_dirty;
            if (set_valid) tg[cache_addr[5:0]] <= cache_addr[15:6];
        end
    end

    // main memory with a programmable number of wait cycles
    assign mem_ready = mem_req && (wcnt >= mem_wait);
    assign mem_rdata = wrt[mem_addr] ? mem[mem_addr] : preload(mem_addr);
    always @(posedge clk) begin
        wcnt <= (!mem_req || mem_ready || reset) ? 0 : wcnt + 1;
        if (mem_req && mem_ready && mem_we && !reset) begin
            mem[mem_addr] <= mem_wdata;
            wrt[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_req && !reset) begin
            chk("mem_pending", 32'(mem_q.size() > 0), 32'd1);
            if (mem_q.size() > 0) begin
                chk("mem_we", 32'(mem_we), 32'(mem_q[0].we));
                chk("mem_addr", 32'(mem_addr), 32'(mem_q[0].addr));
                if (mem_ready) begin
                    if (mem_q[0].we) chk("mem_wdata", mem_wdata, mem_q[0].data);
                    void'(mem_q.pop_front());
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                          input logic cd, input logic [31:0] ed, input int lat);
        int n;
        logic got;
        cpu_exp_t e;
        cpu_q.push_back('{cd, ed, lat});
        @(negedge clk);
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = wd;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = cpu_ready;
        end
        e = cpu_q.pop_front();
        chk("cpu_ready_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(n), 32'(e.lat));
            if (e.cd) chk("cpu_rdata", cpu_rdata, e.data);
        end
        // request stays asserted through the ready cycle to prove it is not re-accepted
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input int h, input int m, input int w);
        chk({tag, "_hit"}, 32'(hit_count), 32'(h));
        chk({tag, "_miss"}, 32'(miss_count), 32'(m));
        chk({tag, "_wb"}, 32'(wb_count), 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_we_cache", 32'(we_cache), 32'd0);
        chk("rst_cache_addr", 32'(cache_addr), 32'd0);
        chk_counts("rst", 0, 0, 0);
        reset = 1'b0;
        // cold read miss, zero-wait refill
        mem_q.push_back('{1'b0, 16'h0045, 32'h0});
        do_req(1, 0, 16'h0045, 32'h0, 1, 32'hDEADBEEF, 4);
        chk_counts("t1", 0, 1, 0);
        // write hit, then read it back
        do_req(0, 1, 16'h0045, 32'h12345678, 0, 32'h0, 2);
        chk("t2_dirty", 32'(dty[5]), 32'd1);
        chk("t2_data", dat[5], 32'h12345678);
        do_req(1, 0, 16'h0045, 32'h0, 1, 32'h12345678, 2);
        chk_counts("t2", 2, 1, 0);
        // dirty eviction of index 5
        mem_q.push_back('{1'b1, 16'h0045, 32'h12345678});
        mem_q.push_back('{1'b0, 16'h0085, 32'h0});
        do_req(1, 0, 16'h0085, 32'h0, 1, 32'hA5A50085, 5);
        chk_counts("t3", 2, 2, 1);
        chk("t3_dirty", 32'(dty[5]), 32'd0);
        chk("t3_tag", 32'(tg[5]), 32'd2);
        chk("t3_q", 32'(mem_q.size()), 32'd0);
        // three memory wait cycles on refill
        mem_wait = 3;
        mem_q.push_back('{1'b0, 16'h0107, 32'h0});
        do_req(1, 0, 16'h0107, 32'h0, 1, 32'hA5A50107, 7);
        chk_counts("t4", 2, 3, 1);
        chk("t4_q", 32'(mem_q.size()), 32'd0);
        // reset while waiting in refill
        mem_wait = 10;
        mem_q.push_back('{1'b0, 16'h0209, 32'h0});
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = 16'h0209;
        repeat (2) @(negedge clk);
        chk("t5_in_refill", 32'(mem_req), 32'd1);
        cpu_rd = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        chk("t5_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("t5_valid9", 32'(vld[9]), 32'd0);
        chk_counts("t5", 0, 0, 0);
        mem_q.delete();
        reset = 1'b0;
        mem_wait = 0;
        mem_q.push_back('{1'b0, 16'h0209, 32'h0});
        do_req(1, 0, 16'h0209, 32'h0, 1, 32'hA5A50209, 4);
        chk_counts("t5b", 0, 1, 0);
        // simultaneous read and write on a hit behaves as a write
        do_req(1, 1, 16'h0209, 32'hCAFEF00D, 0, 32'h0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_single_pulse", 32'(cpu_ready), 32'd0);
        end
        chk("t6_dirty", 32'(dty[9]), 32'd1);
        chk("t6_data", dat[9], 32'hCAFEF00D);
        do_req(1, 0, 16'h0209, 32'h0, 1, 32'hCAFEF00D, 2);
        chk_counts("t6", 2, 1, 0);
        chk("end_mem_q", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
